// File: rtl/fpr_wb_scheduler_if.sv
// fpr_wb_scheduler_if: ID-side issue/load handshake, write-back and scoreboard signals of the FPR write-port scheduler
//   slave  : scheduler view (requests in, ready/stall/write-back/busy out)
//   master : ID/load-unit view
//   FPR_WB_BYPASS_EN adds byp_a/byp_b operand-bypass selects
interface fpr_wb_scheduler_if;
   logic        issue_valid;
   logic [3:0]  issue_lat;
   logic [4:0]  issue_rs;
   logic [4:0]  issue_rt;
   logic        issue_uses_rt;
   logic [4:0]  issue_rd;
   logic        issue_ready;
   logic        ld_valid;
   logic [4:0]  ld_rd;
   logic        ld_ready;
   logic        stall;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] busy_vec;
   logic        flush;
   logic        lat_err;
`ifdef FPR_WB_BYPASS_EN
   logic        byp_a;
   logic        byp_b;
`endif
   modport slave (
      input  issue_valid, issue_lat, issue_rs, issue_rt, issue_uses_rt, issue_rd, ld_valid, ld_rd, flush,
      output issue_ready, ld_ready, stall, wb_valid, wb_rd, busy_vec, lat_err
`ifdef FPR_WB_BYPASS_EN
      , output byp_a, byp_b
`endif
   );
   modport master (
      output issue_valid, issue_lat, issue_rs, issue_rt, issue_uses_rt, issue_rd, ld_valid, ld_rd, flush,
      input  issue_ready, ld_ready, stall, wb_valid, wb_rd, busy_vec, lat_err
`ifdef FPR_WB_BYPASS_EN
      , input byp_a, byp_b
`endif
   );
endinterface

// File: rtl/fpr_wb_scheduler.sv
// fpr_wb_scheduler: issue scheduler and scoreboard for the FPR file's single write port
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : fpr_wb_scheduler_if.slave (issue/load requests, ready/stall, write-back, busy_vec, flush, lat_err)
//   FPR_WB_BYPASS_EN : treat the write-back rd as not busy for RAW and drive byp_a/byp_b
module fpr_wb_scheduler #(
   parameter int MAX_LAT = 8,
   parameter int LD_LAT  = 2
) (
   input logic               clk,
   input logic               reset,
   fpr_wb_scheduler_if.slave bus
);
   localparam logic [4:0] MAX_LAT_W = 5'(MAX_LAT);
   localparam logic [3:0] LD_LAT_W  = 4'(LD_LAT);
   // ring slot 1 is the write-back register itself; slot k writes k-1 cycles from now
   logic [MAX_LAT:1]      v_q, v_d;
   logic [MAX_LAT:1][4:0] rd_q, rd_d;
   logic [31:0]           busy_q, busy_d, raw_busy, slot_v, wb_clr;
   logic                  lat_err_q, lat_err_d;
   logic                  lat_ok, iss_ok, ld_ok;
   logic [4:0]            iss_slot;
   always_comb begin
      slot_v   = 32'({v_q, 1'b0});
      iss_slot = {1'b0, bus.issue_lat} + 5'd1;
      lat_ok   = (bus.issue_lat != 4'd0) && ({1'b0, bus.issue_lat} <= MAX_LAT_W);
      wb_clr   = v_q[1] ? (32'd1 << rd_q[1]) : 32'd0;
`ifdef FPR_WB_BYPASS_EN
      raw_busy = busy_q & ~wb_clr;
`else
      raw_busy = busy_q;
`endif
      ld_ok    = reset & ~bus.flush & bus.ld_valid & ~slot_v[LD_LAT+1] & ~busy_q[bus.ld_rd];
      iss_ok   = reset & ~bus.flush & bus.issue_valid & lat_ok
               & ~raw_busy[bus.issue_rs]
               & ~(bus.issue_uses_rt & raw_busy[bus.issue_rt])
               & ~busy_q[bus.issue_rd]
               & ~slot_v[iss_slot]
               & ~(ld_ok & (bus.issue_lat == LD_LAT_W))
               & ~(ld_ok & (bus.ld_rd == bus.issue_rd));
   end
   always_comb begin
      v_d       = v_q >> 1;
      rd_d      = rd_q >> 5;
      for (int k = 1; k <= MAX_LAT; k++) begin
         if (iss_ok && bus.issue_lat == 4'(k)) begin
            v_d[k]  = 1'b1;
            rd_d[k] = bus.issue_rd;
         end
         if (ld_ok && k == LD_LAT) begin
            v_d[k]  = 1'b1;
            rd_d[k] = bus.ld_rd;
         end
      end
      busy_d    = (busy_q & ~wb_clr)
                | (iss_ok ? (32'd1 << bus.issue_rd) : 32'd0)
                | (ld_ok ? (32'd1 << bus.ld_rd) : 32'd0);
      lat_err_d = lat_err_q | (bus.issue_valid & ~lat_ok);
      if (bus.flush) begin
         v_d    = '0;
         rd_d   = '0;
         busy_d = '0;
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v_q       <= '0;
         rd_q      <= '0;
         busy_q    <= '0;
         lat_err_q <= 1'b0;
      end else begin
         v_q       <= v_d;
         rd_q      <= rd_d;
         busy_q    <= busy_d;
         lat_err_q <= lat_err_d;
      end
   end
   assign bus.issue_ready = iss_ok;
   assign bus.ld_ready    = ld_ok;
   assign bus.stall       = bus.issue_valid & ~iss_ok;
   assign bus.wb_valid    = v_q[1];
   assign bus.wb_rd       = rd_q[1];
   assign bus.busy_vec    = busy_q;
   assign bus.lat_err     = lat_err_q;
`ifdef FPR_WB_BYPASS_EN
   assign bus.byp_a = v_q[1] & (bus.issue_rs == rd_q[1]);
   assign bus.byp_b = v_q[1] & bus.issue_uses_rt & (bus.issue_rt == rd_q[1]);
`endif
endmodule

// File: tb/tb_fpr_wb_scheduler.sv
// tb_fpr_wb_scheduler: scoreboard bench for fpr_wb_scheduler write-back timing, hazards, flush and reset
module tb_fpr_wb_scheduler;
   typedef struct {
      logic [4:0] rd;
      int         cyc;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   exp_t e;
   int   t0;
   fpr_wb_scheduler_if bus();
   fpr_wb_scheduler dut (.clk(clk), .reset(rst_n), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   task automatic push(input logic [4:0] rd, input int c);
      exp_t x;
      x.rd  = rd;
      x.cyc = c;
      q.push_back(x);
   endtask
   task automatic idle();
      bus.issue_valid   = 1'b0;
      bus.issue_lat     = 4'd0;
      bus.issue_rs      = 5'd0;
      bus.issue_rt      = 5'd0;
      bus.issue_uses_rt = 1'b0;
      bus.issue_rd      = 5'd0;
      bus.ld_valid      = 1'b0;
      bus.ld_rd         = 5'd0;
      bus.flush         = 1'b0;
   endtask
   task automatic iss(input logic [3:0] lat, input logic [4:0] rs, input logic [4:0] rd);
      bus.issue_valid = 1'b1;
      bus.issue_lat   = lat;
      bus.issue_rs    = rs;
      bus.issue_rd    = rd;
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   always @(negedge clk) begin
      if (rst_n && bus.wb_valid) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL wb_unexpected: got rd %0d at cycle %0d, required no write", bus.wb_rd, cyc);
         end else begin
            e = q.pop_front();
            if (bus.wb_rd !== e.rd || cyc != e.cyc) begin
               errors++;
               $display("FAIL wb_order: got rd %0d at cycle %0d, required rd %0d at cycle %0d", bus.wb_rd, cyc, e.rd, e.cyc);
            end
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
   initial begin
      idle();
      repeat (2) @(posedge clk);
      #1;
      iss(4'd3, 5'd0, 5'd1);
      bus.ld_valid = 1'b1;
      #1;
      chk("rst_issue_ready", bus.issue_ready, 1'b0);
      chk("rst_ld_ready", bus.ld_ready, 1'b0);
      chk("rst_busy", bus.busy_vec, 32'd0);
      chk("rst_wb_valid", bus.wb_valid, 1'b0);
      chk("rst_wb_rd", bus.wb_rd, 5'd0);
      chk("rst_lat_err", bus.lat_err, 1'b0);
      idle();
      @(negedge clk) rst_n = 1'b1;
      step();
      // latency-3 write and a RAW consumer of its result
      t0 = cyc;
      iss(4'd3, 5'd0, 5'd4);
      #1 chk("t1_ready", bus.issue_ready, 1'b1);
      push(5'd4, t0 + 3);
      step();
      iss(4'd1, 5'd4, 5'd20);
      #1 chk("t1_busy_c1", bus.busy_vec[4], 1'b1);
      chk("t2_stall_c1", bus.stall, 1'b1);
      step();
      #1 chk("t2_stall_c2", bus.stall, 1'b1);
      chk("t1_busy_c2", bus.busy_vec[4], 1'b1);
      step();
`ifdef FPR_WB_BYPASS_EN
      #1 chk("t2_stall_c3", bus.stall, 1'b0);
      chk("t2_byp_a_c3", bus.byp_a, 1'b1);
      push(5'd20, t0 + 4);
      step();
      idle();
      #1 chk("t1_busy_c4", bus.busy_vec[4], 1'b0);
`else
      #1 chk("t2_stall_c3", bus.stall, 1'b1);
      step();
      #1 chk("t1_busy_c4", bus.busy_vec[4], 1'b0);
      chk("t2_stall_c4", bus.stall, 1'b0);
      push(5'd20, t0 + 5);
      step();
      idle();
`endif
      repeat (4) step();
      // write-slot conflict: lat5 then lat3 landing on the same cycle
      t0 = cyc;
      iss(4'd5, 5'd0, 5'd1);
      #1 chk("t3_first_ready", bus.issue_ready, 1'b1);
      push(5'd1, t0 + 5);
      step();
      idle();
      step();
      iss(4'd3, 5'd0, 5'd2);
      #1 chk("t3_slot_stall", bus.stall, 1'b1);
      step();
      #1 chk("t3_second_ready", bus.issue_ready, 1'b1);
      push(5'd2, t0 + 6);
      step();
      idle();
      repeat (5) step();
      // load and FP op wanting the same slot: load wins
      t0 = cyc;
      bus.ld_valid = 1'b1;
      bus.ld_rd    = 5'd7;
      iss(4'd2, 5'd0, 5'd9);
      #1 chk("t4_ld_ready", bus.ld_ready, 1'b1);
      chk("t4_issue_blocked", bus.issue_ready, 1'b0);
      push(5'd7, t0 + 2);
      step();
      bus.ld_valid = 1'b0;
      #1 chk("t4_issue_next", bus.issue_ready, 1'b1);
      push(5'd9, t0 + 3);
      step();
      idle();
      repeat (4) step();
      chk("t4_lat_err_clear", bus.lat_err, 1'b0);
      // flush with three writes in flight, then illegal latencies
      iss(4'd8, 5'd0, 5'd10);
      #1 chk("t5_lat8_ready", bus.issue_ready, 1'b1);
      step();
      iss(4'd5, 5'd0, 5'd11);
      #1 chk("t5_lat5_ready", bus.issue_ready, 1'b1);
      step();
      iss(4'd3, 5'd0, 5'd12);
      #1 chk("t5_lat3_ready", bus.issue_ready, 1'b1);
      step();
      iss(4'd2, 5'd0, 5'd13);
      bus.ld_valid = 1'b1;
      bus.ld_rd    = 5'd14;
      bus.flush    = 1'b1;
      #1 chk("t5_busy_pre", bus.busy_vec, 32'h0000_1C00);
      chk("t5_flush_issue", bus.issue_ready, 1'b0);
      chk("t5_flush_ld", bus.ld_ready, 1'b0);
      step();
      idle();
      #1 chk("t5_busy_post", bus.busy_vec, 32'd0);
      chk("t5_wb_post", bus.wb_valid, 1'b0);
      iss(4'd9, 5'd0, 5'd15);
      #1 chk("t5_lat9_ready", bus.issue_ready, 1'b0);
      chk("t5_lat9_stall", bus.stall, 1'b1);
      step();
      #1 chk("t5_lat_err_set", bus.lat_err, 1'b1);
      iss(4'd0, 5'd0, 5'd15);
      #1 chk("t5_lat0_ready", bus.issue_ready, 1'b0);
      step();
      idle();
      repeat (8) step();
      chk("t5_lat_err_held", bus.lat_err, 1'b1);
      // reset between issue and write-back drops the write
      iss(4'd4, 5'd0, 5'd5);
      #1 chk("t6_ready", bus.issue_ready, 1'b1);
      step();
      idle();
      #1 chk("t6_busy", bus.busy_vec[5], 1'b1);
      step();
      rst_n = 1'b0;
      bus.ld_valid = 1'b1;
      bus.ld_rd    = 5'd3;
      #1 chk("t6_rst_busy", bus.busy_vec, 32'd0);
      chk("t6_rst_wb", bus.wb_valid, 1'b0);
      chk("t6_rst_lat_err", bus.lat_err, 1'b0);
      chk("t6_rst_ld_ready", bus.ld_ready, 1'b0);
      repeat (3) @(posedge clk);
      idle();
      @(negedge clk) rst_n = 1'b1;
      repeat (6) step();
      chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fpr_wb_scheduler.md
Name: fpr_wb_scheduler

Overview:
- Issue scheduler and scoreboard for the floating-point register file's single write port.
- Sits beside the ID stage. Each cycle it decides whether the FP operation in ID, and a pending FP load, may issue.
- Tracks which FPRs have results in flight and reserves the write-port cycle for each result.
- Drives the FPR file's regWr/Rw at write-back, and raises stall toward ID on RAW, WAW or write-port conflicts.

Parameters:
- MAX_LAT, 8, depth of the write-port reservation ring; largest legal issue latency.
- LD_LAT, 2, fixed cycles from FP-load acceptance to its FPR write.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- issue_valid  in  1  FP op present in ID
- issue_lat  in  4  cycles from issue to result write (legal 1..MAX_LAT)
- issue_rs  in  5  source A FPR
- issue_rt  in  5  source B FPR
- issue_uses_rt  in  1  source B is read
- issue_rd  in  5  destination FPR
- issue_ready  out  1  FP op may issue this cycle (combinational)
- ld_valid  in  1  FP load requests a write slot
- ld_rd  in  5  FP load destination
- ld_ready  out  1  load accepted this cycle (combinational)
- stall  out  1  issue_valid & ~issue_ready, to ID
- wb_valid  out  1  FPR write this cycle (to fprFile regWr)
- wb_rd  out  5  FPR written (to fprFile Rw)
- busy_vec  out  32  bit i set = FPR i has a write in flight
- flush  in  1  synchronous kill of all in-flight reservations
- lat_err  out  1  sticky: illegal issue_lat seen with issue_valid

Behaviour:
- Reset (reset=0, asynchronous): ring empty, busy_vec=0, wb_valid=0, wb_rd=0, lat_err=0. Held in reset, issue_ready and ld_ready are 0.
- Ring: entries 1..MAX_LAT, each {v, rd}.
- Every posedge:
  - wb_valid/wb_rd <= entry[1].
  - entry[k] <= entry[k+1]; entry[MAX_LAT] <= empty.
  - Accepted requests are inserted after the shift: issue into entry[issue_lat], load into entry[LD_LAT].
- Latency: an op accepted in cycle t has wb_valid=1, wb_rd=rd during cycle t+L.
- busy[rd] is set at the acceptance edge. It clears at the edge ending the wb_valid cycle for that rd.
- ld_ready = ld_valid & ~entry[LD_LAT+1].v & ~busy[ld_rd].
  - An entry beyond MAX_LAT is always empty.
  - The load has priority over the FP op.
- issue_ready = issue_valid, with all of the following true:
  - 1 <= issue_lat <= MAX_LAT
  - ~busy[issue_rs]
  - ~(issue_uses_rt & busy[issue_rt])
  - ~busy[issue_rd] (WAW)
  - ~entry[issue_lat+1].v (write-port conflict)
  - ~(ld_ready & issue_lat==LD_LAT)
  - ~(ld_ready & ld_rd==issue_rd)
- Simultaneous load and issue to different slots and rds: both accepted on the same edge.
- wb_rd equal to a requested source while busy: stall. The clear occurs at the end of the write-back cycle; no same-cycle bypass unless the feature is enabled.
- issue_lat 0 or >MAX_LAT with issue_valid: issue_ready=0, lat_err<=1. lat_err is cleared only by reset.
- flush=1 at an edge:
  - ring and busy_vec cleared; wb_valid<=0.
  - Requests presented in the same cycle are not inserted; issue_ready and ld_ready are forced 0 while flush=1.
- Reset asserted mid-flight: every pending write is dropped immediately.

Optional Feature:
- Macro: FPR_WB_BYPASS_EN.
- Enabled:
  - During a wb_valid cycle, the RAW check treats wb_rd as not busy.
  - Adds outputs byp_a and byp_b (1 bit each), asserted when issue_rs / issue_rt (with issue_uses_rt) equal wb_rd and wb_valid=1. ID then selects FBUS_W for that operand.
  - WAW on wb_rd still stalls.
- Disabled: byp_a and byp_b are absent; a consumer stalls through the write-back cycle.

Test Plan:
- Reset then issue lat=3 rd=4 at cycle 0 -> busy_vec[4]=1 from cycle 1; wb_valid=1, wb_rd=4 at cycle 3 only; busy_vec[4]=0 from cycle 4.
- Issue lat=3 rd=4 at cycle 0; at cycle 1 issue rs=4 -> stall=1 through cycle 3 (macro off) or through cycle 2 with byp_a=1 at cycle 3 (macro on).
- Issue lat=5 rd=1 at cycle 0; at cycle 2 issue lat=3 rd=2 (same write slot) -> stall at cycle 2; accepted cycle 3; writes at cycles 5 (rd 1) and 6 (rd 2).
- ld_valid rd=7 and issue lat=LD_LAT=2 rd=9 in the same cycle -> ld_ready=1, issue_ready=0; load writes rd 7 two cycles later; the FP op issues next cycle.
- Three ops in flight, flush=1 -> next cycle busy_vec=0, no wb_valid pulses afterward; issue_lat=0 with issue_valid -> lat_err=1 held until reset=0.
- reset=0 asserted between issue and write-back of rd=5 -> wb_valid never pulses; busy_vec=0 immediately.
